controle_ataque: RTL and testbench

Attack-phase controller for the battleship board. It debounces the fire button and validates the row/column switch coordinate. It scores each shot against the 35-cell ship map and keeps per-cell shot/hit masks for the LED-matrix scanner, plus shot/hit counters for the 7-segment display and the result LEDs. It sits between the switch/button inputs, the map decoder and the display multiplexers, and replaces the per-cell check units and the button-clocked LED flop.

---
 rtl/batalha_pkg.sv | 22 ++
 rtl/filtro_botao.sv | 45 ++++
 rtl/controle_ataque.sv | 207 ++++++++++++++++++++
 tb/tb_controle_ataque.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/batalha_pkg.sv
// Shared constants and types for the battleship attack-phase logic:
// board geometry, CH1:CH0 mode codes and the attack FSM state type.
package batalha_pkg;

    localparam int unsigned NUM_LINHAS  = 7;
    localparam int unsigned NUM_COLUNAS = 5;
    localparam int unsigned NUM_CELULAS = 35;

    localparam logic [1:0] MODO_DESL0  = 2'b00;
    localparam logic [1:0] MODO_ATAQUE = 2'b01;
    localparam logic [1:0] MODO_POSIC  = 2'b10;
    localparam logic [1:0] MODO_DESL1  = 2'b11;

    typedef enum logic [2:0] {
        INICIO,
        OCIOSO,
        CALCULA,
        ATUALIZA,
        FIM
    } estado_ataque_t;

endpackage

// File: rtl/filtro_botao.sv
// Fire-button conditioner: 2-flop synchronizer, debounce counter and
// a single-cycle event on each debounced press (high-to-low).
module filtro_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic evento
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          estavel;
    logic [CW-1:0] cont;
    logic          mudou;
    logic          aceita;

    // cont counts how long the synchronized level has differed from the
    // accepted level; reaching DEBOUNCE_CYCLES-1 means DEBOUNCE_CYCLES cycles.
    assign mudou  = (sync[1] != estavel);
    assign aceita = mudou && (cont == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '1;
            estavel <= 1'b1;
            cont    <= '0;
            evento  <= 1'b0;
        end else begin
            sync   <= {sync[0], btn_n};
            evento <= aceita && !sync[1];
            if (!mudou) begin
                cont <= '0;
            end else if (aceita) begin
                estavel <= sync[1];
                cont    <= '0;
            end else begin
                cont <= cont + CW'(1);
            end
        end
    end

endmodule

// File: rtl/controle_ataque.sv
// Attack-phase controller: validates and scores shots against the ship
// map, keeps shot/hit masks and counters, and drives result LEDs.
module controle_ataque
    import batalha_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MAX_TIROS       = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             modo,
    input  logic                   b0_n,
    input  logic [2:0]             linha,
    input  logic [2:0]             coluna,
    input  logic [NUM_CELULAS-1:0] mapa,
    output logic [NUM_CELULAS-1:0] tiros,
    output logic [NUM_CELULAS-1:0] acertos,
    output logic [5:0]             num_tiros,
    output logic [5:0]             num_acertos,
    output logic                   led_g,
    output logic                   led_r,
    output logic                   tiro_ok,
    output logic                   tiro_erro,
    output logic                   fim_jogo,
    output logic                   vitoria
);

    estado_ataque_t estado, prox;

    logic       disparo;
    logic [5:0] alvos;
    logic [5:0] contagem;
    logic [5:0] idx_q, idx_c;
    logic       valido_q, valido_c;
    logic       hit_q, hit_c;
    logic       em_faixa;
    logic       led_hit, led_miss;

    logic [NUM_CELULAS-1:0] tiros_n, acertos_n;
    logic [5:0]             nt_n, na_n;
    logic                   lh_n, lm_n, fim_n, vit_n, ok_n, erro_n;

    filtro_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
        .clk   (clk),
        .rst   (rst),
        .btn_n (b0_n),
        .evento(disparo)
    );

    function automatic logic [5:0] popcount(input logic [NUM_CELULAS-1:0] v);
        logic [5:0] s;
        s = '0;
        for (int unsigned i = 0; i < NUM_CELULAS; i++) begin
            s = s + 6'(v[i]);
        end
        return s;
    endfunction

    assign contagem = popcount(mapa);
    assign em_faixa = (linha <= 3'(NUM_LINHAS - 1)) && (coluna <= 3'(NUM_COLUNAS - 1));
    assign idx_c    = 6'(linha) * 6'(NUM_COLUNAS) + 6'(coluna);
    // Mask/map bits are only looked at for in-range coordinates.
    assign valido_c = em_faixa && !tiros[idx_c];
    assign hit_c    = em_faixa && mapa[idx_c];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= INICIO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox      = estado;
        tiros_n   = tiros;
        acertos_n = acertos;
        nt_n      = num_tiros;
        na_n      = num_acertos;
        lh_n      = led_hit;
        lm_n      = led_miss;
        fim_n     = fim_jogo;
        vit_n     = vitoria;
        ok_n      = 1'b0;
        erro_n    = 1'b0;

        unique case (estado)
            INICIO: begin
                tiros_n   = '0;
                acertos_n = '0;
                nt_n      = '0;
                na_n      = '0;
                lh_n      = 1'b0;
                lm_n      = 1'b0;
                fim_n     = 1'b0;
                vit_n     = 1'b0;
                // The live popcount equals the alvos value latched this cycle.
                if (modo == MODO_ATAQUE) begin
                    if (contagem == '0) begin
                        prox  = FIM;
                        fim_n = 1'b1;
                        vit_n = 1'b1;
                    end else begin
                        prox = OCIOSO;
                    end
                end
            end
            OCIOSO: begin
                if (modo == MODO_POSIC) begin
                    prox = INICIO;
                end else if (modo == MODO_ATAQUE && disparo) begin
                    prox = CALCULA;
                end
            end
            CALCULA: begin
                if (modo == MODO_POSIC) begin
                    prox = INICIO;
                end else if (modo == MODO_ATAQUE) begin
                    prox = ATUALIZA;
                end else begin
                    prox = OCIOSO;
                end
            end
            ATUALIZA: begin
                if (modo == MODO_POSIC) begin
                    prox = INICIO;
                end else if (modo == MODO_ATAQUE) begin
                    if (valido_q) begin
                        tiros_n[idx_q] = 1'b1;
                        if (hit_q) begin
                            acertos_n[idx_q] = 1'b1;
                            na_n             = num_acertos + 6'd1;
                        end
                        nt_n = num_tiros + 6'd1;
                        lh_n = hit_q;
                        lm_n = !hit_q;
                        ok_n = 1'b1;
                    end else begin
                        erro_n = 1'b1;
                    end
                    if (na_n == alvos) begin
                        prox  = FIM;
                        fim_n = 1'b1;
                        vit_n = 1'b1;
                    end else if (nt_n == 6'(MAX_TIROS)) begin
                        prox  = FIM;
                        fim_n = 1'b1;
                        vit_n = 1'b0;
                    end else begin
                        prox = OCIOSO;
                    end
                end
            end
            FIM: begin
                if (modo == MODO_POSIC) begin
                    prox = INICIO;
                end
            end
            default: prox = INICIO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tiros       <= '0;
            acertos     <= '0;
            num_tiros   <= '0;
            num_acertos <= '0;
            led_hit     <= 1'b0;
            led_miss    <= 1'b0;
            led_g       <= 1'b0;
            led_r       <= 1'b0;
            tiro_ok     <= 1'b0;
            tiro_erro   <= 1'b0;
            fim_jogo    <= 1'b0;
            vitoria     <= 1'b0;
            alvos       <= '0;
            idx_q       <= '0;
            valido_q    <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            tiros       <= tiros_n;
            acertos     <= acertos_n;
            num_tiros   <= nt_n;
            num_acertos <= na_n;
            led_hit     <= lh_n;
            led_miss    <= lm_n;
            led_g       <= lh_n && (modo == MODO_ATAQUE);
            led_r       <= lm_n && (modo == MODO_ATAQUE);
            tiro_ok     <= ok_n;
            tiro_erro   <= erro_n;
            fim_jogo    <= fim_n;
            vitoria     <= vit_n;
            if (estado == INICIO) begin
                alvos <= contagem;
            end
            if (estado == CALCULA) begin
                idx_q    <= idx_c;
                valido_q <= valido_c;
                hit_q    <= hit_c;
            end
        end
    end

endmodule

// File: tb/tb_controle_ataque.sv
// Directed self-checking bench for controle_ataque with a short debounce
// period and a 3-shot budget.
module tb_controle_ataque;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  modo = 2'b00;
    logic        b0_n = 1'b1;
    logic [2:0]  linha = '0;
    logic [2:0]  coluna = '0;
    logic [34:0] mapa = '0;
    logic [34:0] tiros, acertos;
    logic [5:0]  num_tiros, num_acertos;
    logic        led_g, led_r, tiro_ok, tiro_erro, fim_jogo, vitoria;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ok_cnt  = 0;
    int unsigned erro_cnt = 0;
    int unsigned ok_base, erro_base;
    logic        visto;
    logic [34:0] um = 35'd1;

    controle_ataque #(
        .DEBOUNCE_CYCLES(4),
        .MAX_TIROS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .modo       (modo),
        .b0_n       (b0_n),
        .linha      (linha),
        .coluna     (coluna),
        .mapa       (mapa),
        .tiros      (tiros),
        .acertos    (acertos),
        .num_tiros  (num_tiros),
        .num_acertos(num_acertos),
        .led_g      (led_g),
        .led_r      (led_r),
        .tiro_ok    (tiro_ok),
        .tiro_erro  (tiro_erro),
        .fim_jogo   (fim_jogo),
        .vitoria    (vitoria)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tiro_ok)   ok_cnt++;
        if (tiro_erro) erro_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] l, input logic [2:0] c);
        linha = l;
        coluna = c;
        ok_base = ok_cnt;
        erro_base = erro_cnt;
        b0_n = 1'b0;
        ciclos(20);
        b0_n = 1'b1;
        ciclos(20);
    endtask

    initial begin
        ciclos(3);
        check("rst_tiros", 64'(tiros), 64'h0);
        check("rst_num_tiros", 64'(num_tiros), 64'h0);
        check("rst_fim", 64'(fim_jogo), 64'h0);
        rst = 1'b0;
        ciclos(2);
        check("idle_off_led_g", 64'(led_g), 64'h0);

        // single ship at cell 7: one hit wins
        modo = 2'b10;
        mapa = um << 7;
        ciclos(3);
        modo = 2'b01;
        ciclos(3);
        check("start_fim", 64'(fim_jogo), 64'h0);
        press(3'd1, 3'd2);
        check("win_ok_pulses", 64'(ok_cnt - ok_base), 64'd1);
        check("win_tiros", 64'(tiros), 64'(um << 7));
        check("win_acertos", 64'(acertos), 64'(um << 7));
        check("win_num_acertos", 64'(num_acertos), 64'd1);
        check("win_led_g", 64'(led_g), 64'd1);
        check("win_fim", 64'(fim_jogo), 64'd1);
        check("win_vitoria", 64'(vitoria), 64'd1);

        // three ships at 0,7,34; misses until the 3-shot budget runs out
        mapa = (um << 0) | (um << 7) | (um << 34);
        modo = 2'b10;
        ciclos(3);
        check("relatch_tiros", 64'(tiros), 64'h0);
        check("relatch_num_acertos", 64'(num_acertos), 64'h0);
        check("relatch_fim", 64'(fim_jogo), 64'h0);
        modo = 2'b01;
        ciclos(3);
        press(3'd0, 3'd1);
        check("miss1_ok", 64'(ok_cnt - ok_base), 64'd1);
        check("miss1_led_r", 64'(led_r), 64'd1);
        press(3'd0, 3'd1);
        check("dup_erro", 64'(erro_cnt - erro_base), 64'd1);
        check("dup_ok", 64'(ok_cnt - ok_base), 64'd0);
        check("dup_num_tiros", 64'(num_tiros), 64'd1);
        check("dup_led_r", 64'(led_r), 64'd1);
        check("dup_led_g", 64'(led_g), 64'd0);
        press(3'd7, 3'd0);
        check("linha7_erro", 64'(erro_cnt - erro_base), 64'd1);
        press(3'd0, 3'd5);
        check("coluna5_erro", 64'(erro_cnt - erro_base), 64'd1);
        check("range_tiros", 64'(tiros), 64'(um << 1));
        check("range_num_tiros", 64'(num_tiros), 64'd1);
        press(3'd0, 3'd2);
        press(3'd0, 3'd3);
        check("budget_num_tiros", 64'(num_tiros), 64'd3);
        check("budget_tiros", 64'(tiros), 64'h0e);
        check("budget_acertos", 64'(acertos), 64'h0);
        check("budget_fim", 64'(fim_jogo), 64'd1);
        check("budget_vitoria", 64'(vitoria), 64'd0);
        check("budget_led_r", 64'(led_r), 64'd1);
        press(3'd0, 3'd0);
        check("after_fim_ok", 64'(ok_cnt - ok_base), 64'd0);
        check("after_fim_erro", 64'(erro_cnt - erro_base), 64'd0);
        check("after_fim_num_tiros", 64'(num_tiros), 64'd3);

        // bouncing button, then a clean hold: exactly one shot at (4,4)
        modo = 2'b10;
        ciclos(3);
        modo = 2'b01;
        ciclos(3);
        linha = 3'd4;
        coluna = 3'd4;
        ok_base = ok_cnt;
        for (int i = 0; i < 10; i++) begin
            b0_n = ~b0_n;
            ciclos(2);
        end
        b0_n = 1'b0;
        ciclos(20);
        b0_n = 1'b1;
        ciclos(20);
        check("bounce_ok", 64'(ok_cnt - ok_base), 64'd1);
        check("bounce_tiros", 64'(tiros), 64'(um << 24));

        // off mode freezes: LEDs dark, presses dropped
        modo = 2'b00;
        ciclos(3);
        check("off_led_r", 64'(led_r), 64'd0);
        press(3'd1, 3'd1);
        check("off_ok", 64'(ok_cnt - ok_base), 64'd0);
        check("off_erro", 64'(erro_cnt - erro_base), 64'd0);
        check("off_num_tiros", 64'(num_tiros), 64'd1);
        modo = 2'b01;
        ciclos(3);
        check("back_led_r", 64'(led_r), 64'd1);

        // reset while the shot is in CALCULA
        linha = 3'd2;
        coluna = 3'd2;
        ok_base = ok_cnt;
        b0_n = 1'b0;
        visto = 1'b0;
        for (int i = 0; i < 50 && !visto; i++) begin
            @(negedge clk);
            if (dut.u_filtro.evento) visto = 1'b1;
        end
        check("evento_seen", 64'(visto), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tiros", 64'(tiros), 64'h0);
        check("midrst_num_tiros", 64'(num_tiros), 64'h0);
        check("midrst_led_r", 64'(led_r), 64'h0);
        b0_n = 1'b1;
        modo = 2'b10;
        mapa = um << 24;
        ciclos(3);
        rst = 1'b0;
        ciclos(5);
        check("midrst_no_pulse", 64'(ok_cnt - ok_base), 64'd0);

        // new map with one ship at cell 24
        modo = 2'b01;
        ciclos(3);
        check("newmap_fim", 64'(fim_jogo), 64'd0);
        press(3'd4, 3'd4);
        check("newmap_acertos", 64'(acertos), 64'(um << 24));
        check("newmap_num_acertos", 64'(num_acertos), 64'd1);
        check("newmap_fim_end", 64'(fim_jogo), 64'd1);
        check("newmap_vitoria", 64'(vitoria), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
